pipe_skid_stage: RTL and testbench

//   Parametrised front-end pipeline stage register (IF/ID successor). Carries a
//   {payload, address} beat with valid/ready handshakes on both sides.
//   A 2-entry skid buffer provides full throughput under back-pressure.

---
 rtl/pipe_skid_stage_if.sv | 25 ++
 rtl/pipe_skid_stage.sv | 110 +++++++++++
 tb/tb_pipe_skid_stage.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready beat channel carrying an instruction payload and its address.
// The master drives the beat and the slave returns ready.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;

  modport master (
    output valid,
    output data,
    output addr,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  addr,
    output ready
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Front-end pipeline stage register with a 2-entry skid buffer, flush/stall
// control and a saturating bubble counter.
module pipe_skid_stage #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = 32'h0000_0013,
  parameter int                CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_skid_stage_if.slave  up,
  pipe_skid_stage_if.master dn,
  input  logic             flush,
  input  logic             stall,
  output logic             out_flushed,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic              r_main_valid;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [ADDR_W-1:0] r_main_addr;
  logic [DATA_W-1:0] r_skid_data;
  logic [ADDR_W-1:0] r_skid_addr;
  logic              r_flushed;
  logic [CNT_W-1:0]  r_bcnt;

  logic w_acc_in;
  logic w_drain;
  logic w_empty;
  logic w_one;
  logic w_full;
  logic w_bubble;

  assign w_acc_in = up.valid & ~r_skid_valid;
  assign w_drain  = r_main_valid & dn.ready & ~stall;
  assign w_empty  = ~r_main_valid & ~r_skid_valid;
  assign w_one    = r_main_valid & ~r_skid_valid;
  assign w_full   = r_main_valid & r_skid_valid;
  assign w_bubble = dn.ready & ~r_main_valid & ~flush;

  assign up.ready    = ~r_skid_valid;
  assign dn.valid    = r_main_valid;
  assign dn.data     = r_main_data;
  assign dn.addr     = r_main_addr;
  assign out_flushed = r_flushed;
  assign bubble_cnt  = r_bcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= NOP_VAL;
      r_main_addr  <= '0;
      r_skid_data  <= NOP_VAL;
      r_skid_addr  <= '0;
      r_flushed    <= 1'b1;
      r_bcnt       <= '0;
    end else begin
      r_flushed <= flush;
      if (w_bubble && !(&r_bcnt))
        r_bcnt <= r_bcnt + 1'b1;
      if (flush) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
        r_main_data  <= NOP_VAL;
        r_main_addr  <= '0;
      end else begin
        unique case (1'b1)
          w_empty: begin
            if (w_acc_in) begin
              r_main_valid <= 1'b1;
              r_main_data  <= up.data;
              r_main_addr  <= up.addr;
            end
          end
          w_one: begin
            if (w_acc_in && w_drain) begin
              r_main_data <= up.data;
              r_main_addr <= up.addr;
            end else if (w_acc_in) begin
              r_skid_valid <= 1'b1;
              r_skid_data  <= up.data;
              r_skid_addr  <= up.addr;
            end else if (w_drain) begin
              r_main_valid <= 1'b0;
              r_main_data  <= NOP_VAL;
              r_main_addr  <= '0;
            end
          end
          w_full: begin
            if (w_drain) begin
              r_main_data  <= r_skid_data;
              r_main_addr  <= r_skid_addr;
              r_skid_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A skid entry without a main entry would reorder beats
  a_legal_state: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(!r_main_valid && r_skid_valid)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: accepted beats are queued,
// and a monitor pops and compares each beat leaving the stage.
module tb_pipe_skid_stage;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          stall;
  logic          out_flushed;
  logic [CW-1:0] bubble_cnt;

  pipe_skid_stage_if #(.DATA_W(DW), .ADDR_W(AW)) up ();
  pipe_skid_stage_if #(.DATA_W(DW), .ADDR_W(AW)) dn ();

  pipe_skid_stage #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NOP_VAL(32'h0000_0013),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (up),
    .dn         (dn),
    .flush      (flush),
    .stall      (stall),
    .out_flushed(out_flushed),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat_of(input logic [AW-1:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Monitor: every downstream transfer must match the oldest accepted beat
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb_q.delete();
    end else if (dn.valid && dn.ready && !stall) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h expected=none", dn.addr);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("sb_beat", {dn.data, dn.addr}, e);
      end
    end
  end

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  // Stimulus side records a beat the moment it is accepted
  task automatic neg();
    @(negedge clk);
    if (rst_n && !flush && up.valid && up.ready)
      sb_q.push_back({up.data, up.addr});
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a);
    up.valid = v;
    up.addr  = a;
    up.data  = dat_of(a);
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    dn.ready = 1'b0;
    drive(1'b0, '0);
    pos();
    pos();
    neg();
    chk("rst_out_valid", {63'd0, dn.valid}, 64'd0);
    chk("rst_out_data", {32'd0, dn.data}, 64'h13);
    chk("rst_out_addr", {32'd0, dn.addr}, 64'd0);
    chk("rst_in_ready", {63'd0, up.ready}, 64'd1);
    chk("rst_flushed", {63'd0, out_flushed}, 64'd1);
    chk("rst_bcnt", {60'd0, bubble_cnt}, 64'd0);
    pos();
    rst_n = 1'b1;

    // Streaming at full rate
    dn.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4));
      neg();
      if (i > 0) begin
        chk("stream_valid", {63'd0, dn.valid}, 64'd1);
        chk("stream_addr", {32'd0, dn.addr}, 64'(32'((i - 1) * 4)));
      end
      pos();
    end
    drive(1'b0, '0);
    neg();
    chk("stream_last", {32'd0, dn.addr}, 64'h1c);
    pos();
    neg();
    chk("stream_empty", {63'd0, dn.valid}, 64'd0);
    pos();

    // Back-pressure
    dn.ready = 1'b0;
    drive(1'b1, 32'h100);
    neg();
    chk("bp_rdy1", {63'd0, up.ready}, 64'd1);
    pos();
    drive(1'b1, 32'h104);
    neg();
    chk("bp_rdy2", {63'd0, up.ready}, 64'd1);
    pos();
    drive(1'b1, 32'h108);
    neg();
    chk("bp_rdy3", {63'd0, up.ready}, 64'd0);
    pos();
    drive(1'b0, '0);
    dn.ready = 1'b1;
    neg();
    chk("bp_out0", {32'd0, dn.addr}, 64'h100);
    pos();
    neg();
    chk("bp_out1", {32'd0, dn.addr}, 64'h104);
    pos();
    neg();
    chk("bp_empty_v", {63'd0, dn.valid}, 64'd0);
    chk("bp_empty_d", {32'd0, dn.data}, 64'h13);
    chk("bp_empty_a", {32'd0, dn.addr}, 64'd0);
    pos();

    // Stall holds main; skid still absorbs one beat
    drive(1'b1, 32'h200);
    neg();
    pos();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1'b1, 32'h204);
      else drive(1'b0, '0);
      neg();
      chk("stall_addr", {32'd0, dn.addr}, 64'h200);
      chk("stall_flushed", {63'd0, out_flushed}, 64'd0);
      chk("stall_rdy", {63'd0, up.ready}, (i == 0) ? 64'd1 : 64'd0);
      pos();
    end
    stall = 1'b0;
    drive(1'b0, '0);
    neg();
    chk("stall_rel0", {32'd0, dn.addr}, 64'h200);
    pos();
    neg();
    chk("stall_rel1", {32'd0, dn.addr}, 64'h204);
    pos();
    neg();
    chk("stall_done", {63'd0, dn.valid}, 64'd0);
    pos();

    // Flush while FULL
    dn.ready = 1'b0;
    drive(1'b1, 32'h300);
    neg();
    pos();
    drive(1'b1, 32'h304);
    neg();
    pos();
    drive(1'b1, 32'h308);
    flush = 1'b1;
    neg();
    pos();
    flush = 1'b0;
    drive(1'b0, '0);
    dn.ready = 1'b1;
    neg();
    chk("fl_valid", {63'd0, dn.valid}, 64'd0);
    chk("fl_data", {32'd0, dn.data}, 64'h13);
    chk("fl_addr", {32'd0, dn.addr}, 64'd0);
    chk("fl_flushed", {63'd0, out_flushed}, 64'd1);
    chk("fl_rdy", {63'd0, up.ready}, 64'd1);
    pos();
    neg();
    chk("fl_after", {63'd0, dn.valid}, 64'd0);
    pos();

    // Flush while ONE drops the same-cycle accepted beat
    dn.ready = 1'b0;
    drive(1'b1, 32'h400);
    neg();
    pos();
    drive(1'b1, 32'h404);
    flush = 1'b1;
    neg();
    pos();
    flush = 1'b0;
    drive(1'b0, '0);
    dn.ready = 1'b1;
    neg();
    chk("fl1_valid", {63'd0, dn.valid}, 64'd0);
    pos();
    neg();
    chk("fl1_after", {63'd0, dn.valid}, 64'd0);
    pos();

    // Saturating bubble counter
    rst_n = 1'b0;
    pos();
    pos();
    neg();
    chk("cnt_rst", {60'd0, bubble_cnt}, 64'd0);
    pos();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      neg();
      pos();
    end
    neg();
    chk("cnt_5", {60'd0, bubble_cnt}, 64'd5);
    pos();
    for (int i = 0; i < 15; i++) begin
      neg();
      pos();
    end
    neg();
    chk("cnt_sat", {60'd0, bubble_cnt}, 64'd15);
    pos();
    rst_n = 1'b0;
    pos();
    neg();
    chk("cnt_clr", {60'd0, bubble_cnt}, 64'd0);
    rst_n = 1'b1;

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover actual=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
